mem_bus_fabric: RTL
===================

// Module: mem_bus_fabric
// PURPOSE
//  Parametrised picorv32 native-memory-bus interconnect, replacing hand-written chip-select/ready/rdata glue.
//  Decodes one address field into NUM_SLOTS one-hot selects and gates write strobes per slot.
//  Generates cpu_mem_ready per slot: fixed wait-state count or slave-driven, with a timeout watchdog.
//  Sits between the CPU and the ROM, RAMs, LED, UART and encoder peripherals.
// PARAMETERS
//  NUM_SLOTS    8        number of slave slots (1..16)
//  SEL_LSB      12       lowest address bit of the slot-select field
//  SEL_W        4        select field width; slot = addr[SEL_LSB+:SEL_W]
//  SLOT_LAT     32'h0111_0111  4 bits per slot, slot i at [4i+:4]; 0 = slave-driven ready, 1..15 = fixed cycles
//  TIMEOUT      255      max cycles waiting on a slave-driven slot before error completion
//  ERR_DATA     32'hDEAD_BEEF  rdata returned on an unmapped or timed-out access
// PORTS
//  clk            in   1            system clock
//  rst            in   1            synchronous reset, active-high
//  cpu_mem_valid  in   1            CPU request valid
//  cpu_mem_addr   in   32           CPU byte address
//  cpu_mem_wstrb  in   4            CPU write strobes (0 = read)
//  cpu_mem_ready  out  1            one-cycle completion pulse to CPU
//  cpu_mem_rdata  out  32           read data to CPU
//  slv_cs         out  NUM_SLOTS    one-hot slot select
//  slv_we         out  4            cpu_mem_wstrb gated by any slv_cs
//  slv_ready      in   NUM_SLOTS    per-slot ready (used only when SLOT_LAT[i]==0)
//  slv_rdata      in   NUM_SLOTS*32 per-slot read data, slot i at [32i+:32]
//  bus_err        out  1            one-cycle pulse on unmapped or timeout completion
// BEHAVIOUR
//  - FSM states: IDLE, ACCESS, DONE. Reset -> IDLE; counters 0; all outputs 0.
//  - Selects are decoded combinationally in IDLE, so a slave sees cs on the first valid cycle.
//  - IDLE, valid, slot < NUM_SLOTS: latch slot, cnt<=1, slv_cs asserted, go to ACCESS.
//  - IDLE, valid, slot >= NUM_SLOTS: go to DONE.
//    The next cycle gives ready=1, rdata=ERR_DATA and bus_err=1, with no cs.
//  - ACCESS with fixed latency L: ready=1 when cnt==L, so ready comes L cycles after the first valid cycle.
//    L=1 gives registered-ROM timing.
//  - ACCESS with L=0: ready = slv_ready[slot] combinationally; a zero-wait response is allowed in the IDLE cycle.
//  - Timeout: if cnt reaches TIMEOUT with no slv_ready, complete with ERR_DATA and bus_err=1.
//    Writes to the slave are suppressed from that cycle on.
//  - On completion: rdata = slv_rdata[slot] (or ERR_DATA), cs stays asserted that cycle, then go to DONE.
//  - DONE: cs=0, ready=0, valid ignored for exactly one cycle, then go to IDLE.
//    This prevents re-triggering while the CPU drops valid.
//  - valid low in ACCESS (abort): go to IDLE next cycle, no ready, no bus_err.
//  - rst asserted mid-transfer: IDLE next cycle, ready/cs/bus_err 0; the transfer is never completed.
//  - cnt is 8 bits and saturates; TIMEOUT <= 255 is enforced by an elaboration check.
//  - cpu_mem_rdata = 0 whenever cpu_mem_ready = 0.
// CONFIGURATION
//  BUS_FABRIC_ERR_CAPTURE_EN defined:
//    adds ports err_addr out 32 and err_count out 8.
//    On each bus_err, err_addr <= offending address and err_count increments, saturating at 255.
//    Both reset to 0.
//  Undefined: ports and logic absent; bus_err behaviour is unchanged.
// STRUCTURE
//  Package mem_bus_fabric_pkg holds:
//    the state enum {IDLE, ACCESS, DONE};
//    the default ERR_DATA constant;
//    the function slot_lat(SLOT_LAT, i) returning a 4-bit latency.
//  Sub-module bus_wait_timer holds the cnt register, fixed-latency match and timeout compare.
//    Its ports: start, run, lat, done, timeout.
// TESTING
//  - Read of slot 0 (L=1) at 0x0000_0010 with slv_rdata[0]=0x1234_5678:
//    ready exactly 1 cycle after valid, rdata=0x1234_5678, slv_cs=8'h01.
//  - Write with wstrb=4'b0011 to slot 3 (L=0) at 0x3000, slv_ready[3] high on the same cycle:
//    ready on the same cycle, slv_we=4'b0011, then a 1-cycle DONE gap.
//  - Access to 0x9000 with NUM_SLOTS=8:
//    ready 1 cycle later, rdata=0xDEAD_BEEF, bus_err pulse, slv_cs stays 0.
//  - Slot 4 (L=0) with slv_ready held low and TIMEOUT=16:
//    ready+bus_err at cycle 16, rdata=0xDEAD_BEEF; with the macro, err_addr=0x4000 and err_count=1.
//  - Slot 2 with L=3: drop valid at cycle 1, then rst during a new access -> no ready pulses, FSM back in IDLE.
//  - Back-to-back L=1 reads:
//    exactly one ready per request, cs low during DONE, no duplicate slave access.

Source files
------------

// File: rtl/mem_bus_fabric_pkg.sv
// rtl/mem_bus_fabric_pkg.sv - shared types, constants and helpers for the memory bus fabric
package mem_bus_fabric_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // SLOT_LAT packs one 4-bit latency per slot, slot i at bits [4i+:4]
    function automatic logic [3:0] slot_lat(input logic [63:0] lat_vec, input int i);
        logic [63:0] shifted;
        shifted = lat_vec >> (4 * i);
        return shifted[3:0];
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// rtl/bus_wait_timer.sv - per-access cycle counter with fixed-latency match and timeout compare
module bus_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       run,
    input  logic [3:0] lat,
    output logic       done,
    output logic       timeout
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (start) begin
            cnt <= 8'd1;
        end else if (run && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Fixed-latency slots never time out; slave-driven slots never "match"
    assign done    = run && (lat != 4'd0) && (cnt == {4'd0, lat});
    assign timeout = run && (lat == 4'd0) && (cnt >= 8'(TIMEOUT));

endmodule

// File: rtl/mem_bus_fabric.sv
// rtl/mem_bus_fabric.sv - picorv32 native-bus interconnect: slot decode, wait states, timeout; BUS_FABRIC_ERR_CAPTURE_EN adds error capture
module mem_bus_fabric
    import mem_bus_fabric_pkg::*;
#(
    parameter int          NUM_SLOTS = 8,
    parameter int          SEL_LSB   = 12,
    parameter int          SEL_W     = 4,
    parameter logic [63:0] SLOT_LAT  = 64'h0000_0000_0111_0111,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_mem_valid,
    input  logic [31:0]              cpu_mem_addr,
    input  logic [3:0]               cpu_mem_wstrb,
    output logic                     cpu_mem_ready,
    output logic [31:0]              cpu_mem_rdata,
    output logic [NUM_SLOTS-1:0]     slv_cs,
    output logic [3:0]               slv_we,
    input  logic [NUM_SLOTS-1:0]     slv_ready,
    input  logic [NUM_SLOTS*32-1:0]  slv_rdata,
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
    output logic [31:0]              err_addr,
    output logic [7:0]               err_count,
`endif
    output logic                     bus_err
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_bus_fabric: TIMEOUT must be in 1..255");
    end
    if (NUM_SLOTS < 1 || NUM_SLOTS > 16 || NUM_SLOTS > (1 << SEL_W)) begin : g_bad_slots
        $error("mem_bus_fabric: NUM_SLOTS out of range");
    end

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     slot_q;
    logic                 err_pend_q, err_pend_d;
    logic [SEL_W-1:0]     addr_slot, cur_slot;
    logic                 mapped;
    logic [NUM_SLOTS-1:0] sel_oh;
    logic                 sel_ready;
    logic [31:0]          sel_rdata;
    logic [3:0]           sel_lat;
    logic                 start, run, done, timeout;
    logic                 addr_unused;

    assign addr_slot   = cpu_mem_addr[SEL_LSB +: SEL_W];
    assign mapped      = int'(addr_slot) < NUM_SLOTS;
    assign cur_slot    = (state_q == IDLE) ? addr_slot : slot_q;
    assign addr_unused = ^cpu_mem_addr;

    always_comb begin
        sel_oh    = '0;
        sel_ready = 1'b0;
        sel_rdata = 32'd0;
        sel_lat   = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (cur_slot == SEL_W'(i)) begin
                sel_oh[i] = 1'b1;
                sel_ready = slv_ready[i];
                sel_rdata = slv_rdata[32*i +: 32];
                sel_lat   = slot_lat(SLOT_LAT, i);
            end
        end
    end

    bus_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .run     (run),
        .lat     (sel_lat),
        .done    (done),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_pend_q <= err_pend_d;
            if (start) begin
                slot_q <= addr_slot;
            end
        end
    end

    // Outputs are held low throughout reset so an interrupted transfer never completes
    always_comb begin
        state_d       = state_q;
        err_pend_d    = 1'b0;
        start         = 1'b0;
        run           = 1'b0;
        cpu_mem_ready = 1'b0;
        cpu_mem_rdata = 32'd0;
        slv_cs        = '0;
        slv_we        = 4'd0;
        bus_err       = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (cpu_mem_valid) begin
                        if (mapped) begin
                            start  = 1'b1;
                            slv_cs = sel_oh;
                            slv_we = cpu_mem_wstrb;
                            if ((sel_lat == 4'd0) && sel_ready) begin
                                cpu_mem_ready = 1'b1;
                                cpu_mem_rdata = sel_rdata;
                                state_d       = DONE;
                            end else begin
                                state_d = ACCESS;
                            end
                        end else begin
                            err_pend_d = 1'b1;
                            state_d    = DONE;
                        end
                    end
                end
                ACCESS: begin
                    if (!cpu_mem_valid) begin
                        state_d = IDLE;
                    end else begin
                        run    = 1'b1;
                        slv_cs = sel_oh;
                        slv_we = timeout ? 4'd0 : cpu_mem_wstrb;
                        if ((sel_lat != 4'd0) ? done : sel_ready) begin
                            cpu_mem_ready = 1'b1;
                            cpu_mem_rdata = sel_rdata;
                            state_d       = DONE;
                        end else if (timeout) begin
                            cpu_mem_ready = 1'b1;
                            cpu_mem_rdata = ERR_DATA;
                            bus_err       = 1'b1;
                            state_d       = DONE;
                        end
                    end
                end
                DONE: begin
                    // An unmapped access completes here, then takes one more DONE cycle as its gap
                    if (err_pend_q) begin
                        cpu_mem_ready = 1'b1;
                        cpu_mem_rdata = ERR_DATA;
                        bus_err       = 1'b1;
                        state_d       = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef BUS_FABRIC_ERR_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_addr  <= 32'd0;
            err_count <= 8'd0;
        end else if (bus_err) begin
            err_addr <= cpu_mem_addr;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`endif

endmodule
